// File: rtl/jtdsp16_host_model.sv
// Host/peripheral model for jtdsp16: ROM loader, parallel-port generator/monitor, irq and run-end control.
// Optional rising-edge statistics counters are built when JTDSP16_HOST_STATS_EN is defined.
module jtdsp16_host_model #(
  parameter int            DW        = 16,
  parameter int            AW        = 13,
  parameter int            LOAD_LEN  = 512,
  parameter logic [DW-1:0] IN_INIT   = 16'hBEEF,
  parameter logic [DW-1:0] IRQ_WORD  = 16'hCAFE,
  parameter logic [DW-1:0] END_WORD  = 16'hDEAD,
  parameter int            END_COUNT = 2,
  parameter int            TIMEOUT   = 1500
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-2:0] rom_addr,
  input  logic [15:0]   rom_data,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          dsp_rst,
  output logic [DW-1:0] pbus_in,
  input  logic [DW-1:0] pbus_out,
  input  logic          pids_n,
  input  logic          pods_n,
  input  logic [1:0]    in_mode,
  output logic          irq,
  input  logic          iack,
  output logic          done,
  output logic          timed_out,
  output logic [15:0]   in_cnt,
  output logic [15:0]   out_cnt
);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] prog_addr_nxt;
  logic          prog_we_nxt;
  logic [DW-1:0] pbus_in_nxt;
  logic          irq_nxt, irq_set;
  logic          done_nxt, timed_out_nxt;
  logic [31:0]   end_cnt, end_cnt_nxt;
  logic [31:0]   to_cnt, to_cnt_nxt;
  logic          armed, armed_nxt;
  logic          end_req;
  logic          pids_q, pods_q;
  logic          pids_rise, pods_rise;

  assign rom_addr  = prog_addr[AW-1:1];
  assign prog_data = prog_addr[0] ? rom_data[15:8] : rom_data[7:0];
  assign dsp_rst   = prog_we;
  assign pids_rise = pids_n & ~pids_q;
  assign pods_rise = pods_n & ~pods_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      prog_addr <= '0;
      prog_we   <= 1'b1;
      pbus_in   <= IN_INIT;
      irq       <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      end_cnt   <= '0;
      to_cnt    <= '0;
      armed     <= 1'b1;
      pids_q    <= 1'b1;
      pods_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      prog_addr <= prog_addr_nxt;
      prog_we   <= prog_we_nxt;
      pbus_in   <= pbus_in_nxt;
      irq       <= irq_nxt;
      done      <= done_nxt;
      timed_out <= timed_out_nxt;
      end_cnt   <= end_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      armed     <= armed_nxt;
      pids_q    <= pids_n;
      pods_q    <= pods_n;
    end
  end

  always_comb begin
    state_nxt     = state;
    prog_addr_nxt = prog_addr;
    prog_we_nxt   = prog_we;
    pbus_in_nxt   = pbus_in;
    irq_set       = 1'b0;
    done_nxt      = done;
    timed_out_nxt = timed_out;
    end_cnt_nxt   = end_cnt;
    to_cnt_nxt    = to_cnt;
    armed_nxt     = armed;
    end_req       = 1'b0;
    case (state)
      LOAD: begin
        if (prog_addr == AW'(LOAD_LEN)) begin
          prog_we_nxt = 1'b0;
          state_nxt   = RUN;
        end else begin
          prog_addr_nxt = prog_addr + AW'(1);
        end
      end
      RUN: begin
        if (pids_rise) begin
          case (in_mode)
            2'd0: pbus_in_nxt = pbus_in + DW'(1);
            2'd1: pbus_in_nxt = pbus_in - DW'(1);
            2'd2: pbus_in_nxt = pbus_in;
            default: begin
              if (pbus_in == '0)
                pbus_in_nxt = IN_INIT;
              else if (pbus_in[0])
                pbus_in_nxt = (pbus_in >> 1) ^ DW'(16'hB400);
              else
                pbus_in_nxt = pbus_in >> 1;
            end
          endcase
        end
        if (pods_rise) begin
          if (pbus_out == IRQ_WORD) irq_set = 1'b1;
          if (pbus_out == END_WORD) begin
            end_req     = 1'b1;
            end_cnt_nxt = end_cnt + 32'd1;
            armed_nxt   = 1'b0;
            if (end_cnt + 32'd1 == 32'(END_COUNT)) begin
              done_nxt  = 1'b1;
              state_nxt = DONE;
            end
          end
        end
        // An end word seen this clock disarms the timeout before it can fire.
        if (armed && !end_req && TIMEOUT != 0) begin
          if (to_cnt == 32'(TIMEOUT - 1)) begin
            done_nxt      = 1'b1;
            timed_out_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            to_cnt_nxt = to_cnt + 32'd1;
          end
        end
      end
      default: ;
    endcase
    irq_nxt = irq_set ? 1'b1 : (iack ? 1'b0 : irq);
  end

`ifdef JTDSP16_HOST_STATS_EN
  logic [15:0] in_cnt_r, out_cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else if (state == RUN) begin
      if (pids_rise && in_cnt_r != '1)  in_cnt_r  <= in_cnt_r + 16'd1;
      if (pods_rise && out_cnt_r != '1) out_cnt_r <= out_cnt_r + 16'd1;
    end
  end

  assign in_cnt  = in_cnt_r;
  assign out_cnt = out_cnt_r;
`else
  assign in_cnt  = '0;
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_jtdsp16_host_model.sv
// Self-checking bench for jtdsp16_host_model: load, input generator, irq, end/timeout, mid-run reset.
module tb_jtdsp16_host_model;

  localparam int AW = 13;
`ifdef JTDSP16_HOST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-2:0] rom_addr;
  logic [15:0]   rom_data;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          prog_we, dsp_rst;
  logic [15:0]   pbus_in;
  logic [15:0]   pbus_out = 16'h0000;
  logic          pids_n = 1'b1, pods_n = 1'b1;
  logic [1:0]    in_mode = 2'd0;
  logic          irq, iack = 1'b0;
  logic          done, timed_out;
  logic [15:0]   in_cnt, out_cnt;

  logic [AW-2:0] nt_rom_addr;
  logic [AW-1:0] nt_prog_addr;
  logic [7:0]    nt_prog_data;
  logic          nt_prog_we, nt_dsp_rst, nt_irq, nt_done, nt_timed_out;
  logic [15:0]   nt_pbus_in, nt_in_cnt, nt_out_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  logic [15:0] model_in;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [AW-2:0] a);
    case (a)
      12'd0:   return 16'h1234;
      12'd1:   return 16'hABCD;
      default: return {4'h0, a} ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v == 16'h0000) return 16'hBEEF;
    return v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
  endfunction

  assign rom_data = rom_word(rom_addr);

  jtdsp16_host_model #(.DW(16), .AW(AW), .LOAD_LEN(512), .IN_INIT(16'hBEEF),
    .IRQ_WORD(16'hCAFE), .END_WORD(16'hDEAD), .END_COUNT(2), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we), .dsp_rst(dsp_rst),
    .pbus_in(pbus_in), .pbus_out(pbus_out), .pids_n(pids_n), .pods_n(pods_n),
    .in_mode(in_mode), .irq(irq), .iack(iack), .done(done), .timed_out(timed_out),
    .in_cnt(in_cnt), .out_cnt(out_cnt));

  jtdsp16_host_model #(.DW(16), .AW(AW), .LOAD_LEN(8), .IN_INIT(16'hBEEF),
    .IRQ_WORD(16'hCAFE), .END_WORD(16'hDEAD), .END_COUNT(2), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .rom_addr(nt_rom_addr), .rom_data(16'h0000),
    .prog_addr(nt_prog_addr), .prog_data(nt_prog_data), .prog_we(nt_prog_we), .dsp_rst(nt_dsp_rst),
    .pbus_in(nt_pbus_in), .pbus_out(16'h0000), .pids_n(1'b1), .pods_n(1'b1),
    .in_mode(2'd0), .irq(nt_irq), .iack(1'b0), .done(nt_done), .timed_out(nt_timed_out),
    .in_cnt(nt_in_cnt), .out_cnt(nt_out_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pids(input logic [1:0] mode);
    in_mode = mode;
    pids_n  = 1'b0;
    tick();
    pids_n  = 1'b1;
    tick();
  endtask

  task automatic pulse_pods(input logic [15:0] word);
    pbus_out = word;
    pods_n   = 1'b0;
    tick();
    pods_n   = 1'b1;
    tick();
  endtask

  // Starts just after reset release; ends on the clock that enters RUN.
  task automatic load_sequence();
    exp_q.push_back(16'h0034); exp_q.push_back(16'h0012);
    exp_q.push_back(16'h00CD); exp_q.push_back(16'h00AB);
    for (int k = 0; k <= 513; k++) begin
      if (k < 4) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({8'h00, prog_data} !== exp_v || prog_addr !== AW'(k)) begin
          n_fail++;
          $display("FAIL load_byte%0d: got addr %0d data %h, want addr %0d data %h",
                   k, prog_addr, prog_data, k, exp_v[7:0]);
        end
      end
      if (k == 512) begin
        n_checks++;
        if (prog_we !== 1'b1 || dsp_rst !== 1'b1) begin
          n_fail++;
          $display("FAIL load_we_512: got we %b rst %b, want 1 1", prog_we, dsp_rst);
        end
      end
      if (k == 513) begin
        n_checks++;
        if (prog_we !== 1'b0 || dsp_rst !== 1'b0 || prog_addr !== AW'(512)) begin
          n_fail++;
          $display("FAIL load_we_513: got we %b rst %b addr %0d, want 0 0 512",
                   prog_we, dsp_rst, prog_addr);
        end
      end
      if (k < 513) tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if (prog_addr !== '0 || prog_we !== 1'b1 || dsp_rst !== 1'b1 || pbus_in !== 16'hBEEF ||
        irq !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 || in_cnt !== '0 || out_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got addr %0d we %b rst %b in %h irq %b done %b to %b cnt %0d/%0d",
               prog_addr, prog_we, dsp_rst, pbus_in, irq, done, timed_out, in_cnt, out_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    load_sequence();
  endtask

  task automatic test_timeout();
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (t == 99) begin
        n_checks++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_early: got done %b, want 0", done);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1 || timed_out !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fire: got done %b timed_out %b, want 1 1", done, timed_out);
    end
    pulse_pids(2'd0);
    n_checks++;
    if (pbus_in !== 16'hBEEF || in_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL done_ignores_pids: got in %h cnt %0d, want BEEF 0", pbus_in, in_cnt);
    end
    n_checks++;
    if (nt_done !== 1'b0 || nt_timed_out !== 1'b0 || nt_prog_we !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_zero: got done %b to %b we %b, want 0 0 0",
               nt_done, nt_timed_out, nt_prog_we);
    end
  endtask

  task automatic reload();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_sequence();
  endtask

  task automatic test_input_gen();
    logic [1:0] modes[8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
    model_in = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      case (modes[i])
        2'd0: model_in = model_in + 16'd1;
        2'd1: model_in = model_in - 16'd1;
        2'd3: model_in = lfsr_step(model_in);
        default: ;
      endcase
      exp_q.push_back(model_in);
      pulse_pids(modes[i]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (pbus_in !== exp_v) begin
        n_fail++;
        $display("FAIL input_gen_%0d_mode%0d: got %h, want %h", i, modes[i], pbus_in, exp_v);
      end
    end
    n_checks++;
    if (in_cnt !== (STATS ? 16'd8 : 16'd0)) begin
      n_fail++;
      $display("FAIL in_cnt: got %0d, want %0d", in_cnt, STATS ? 8 : 0);
    end
  endtask

  task automatic test_irq();
    pbus_out = 16'hCAFE;
    pods_n = 1'b0;
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_before_rise: got %b, want 0", irq);
    end
    pods_n = 1'b1;
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got %b, want 1", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_hold: got %b, want 1", irq);
    end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_ack: got %b, want 0", irq);
    end
    pods_n = 1'b0;
    tick();
    pods_n = 1'b1;
    iack   = 1'b1;
    tick();
    iack   = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins: got %b, want 1", irq);
    end
  endtask

  task automatic test_end_disarm();
    pulse_pods(16'hDEAD);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL end_first: got done %b, want 0", done);
    end
    repeat (200) tick();
    n_checks++;
    if (done !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL end_disarm: got done %b to %b, want 0 0", done, timed_out);
    end
    n_checks++;
    if (out_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL out_cnt: got %0d, want %0d", out_cnt, STATS ? 3 : 0);
    end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0 || prog_we !== 1'b1 || prog_addr !== '0 || dsp_rst !== 1'b1 ||
        pbus_in !== 16'hBEEF || in_cnt !== '0 || out_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: got irq %b we %b addr %0d in %h cnt %0d/%0d",
               irq, prog_we, prog_addr, pbus_in, in_cnt, out_cnt);
    end
    tick();
    rst = 1'b0;
    load_sequence();
  endtask

  task automatic test_end_final();
    pulse_pods(16'hCAFE);
    pulse_pods(16'hDEAD);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL end_count_cleared: got done %b, want 0", done);
    end
    pulse_pods(16'hDEAD);
    n_checks++;
    if (done !== 1'b1 || timed_out !== 1'b0 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL end_done: got done %b to %b irq %b, want 1 0 1", done, timed_out, irq);
    end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    pulse_pids(2'd0);
    repeat (120) tick();
    n_checks++;
    if (irq !== 1'b0 || pbus_in !== 16'hBEEF || done !== 1'b1 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got irq %b in %h done %b to %b, want 0 BEEF 1 0",
               irq, pbus_in, done, timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_timeout();
    reload();
    test_input_gen();
    test_irq();
    test_end_disarm();
    test_reset_midrun();
    test_end_final();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
